pipelined_adder: RTL and testbench



---
 rtl/pipelined_adder.sv | 166 ++++++++++++++++
 tb/tb_pipelined_adder.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_adder.sv
// pipelined_adder
//
// Parametrised WIDTH-bit adder/subtractor. The word is split into STAGES
// equal slices of CHUNK = WIDTH/STAGES bits. Stage k ripple-adds slice k
// using the carry registered by stage k-1. Lower slice results computed so
// far travel down the pipe alongside the operands that are still unconsumed.
//
// Handshake (both sides): a transfer happens on a rising clk edge where
// valid and ready are both 1. Once valid is raised, the producer holds its
// data until that transfer. in_ready = !out_valid || out_ready, and it is
// forced low while rst_n is low. When in_ready is 1 every stage loads from
// the stage before it. Otherwise the whole pipe holds. Bubbles are not
// collapsed.
//
// Latency: operands accepted at edge T produce out_valid after edge
// T+STAGES-1. With no stall the pipe accepts one operand pair per cycle.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous, active-low reset
//   in_valid   operands present          in_ready   operands accepted
//   a, b       operands (WIDTH bits)
//   cin        carry-in, add only
//   sub        1 = a - b, 0 = a + b + cin
//   out_valid  result present            out_ready  result accepted
//   sum        result (WIDTH bits)
//   cout       carry-out of MSB (subtract: 1 = no borrow)
//   overflow   signed two's-complement overflow
//
// Optional feature: define SATURATE_EN to make the final stage clamp sum to
// the most positive or most negative value on signed overflow.
module pipelined_adder #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int CHUNK = WIDTH / STAGES;
  localparam int LAST  = STAGES - 1;

  // Stage registers
  logic [STAGES-1:0] vld_q, vld_d;
  logic [STAGES-1:0] c_q, c_d;
  logic [WIDTH-1:0]  a_q [STAGES];
  logic [WIDTH-1:0]  a_d [STAGES];
  logic [WIDTH-1:0]  b_q [STAGES];
  logic [WIDTH-1:0]  b_d [STAGES];
  logic [WIDTH-1:0]  s_q [STAGES];
  logic [WIDTH-1:0]  s_d [STAGES];
  logic              ovf_q, ovf_d;

  // Inputs seen by each stage: stage 0 takes the prepared ports, and later
  // stages take the registers of the stage before them.
  logic [STAGES-1:0] v_st, c_st;
  logic [WIDTH-1:0]  a_st [STAGES];
  logic [WIDTH-1:0]  b_st [STAGES];
  logic [WIDTH-1:0]  s_st [STAGES];

  logic advance;

  assign in_ready = rst_n && (!vld_q[LAST] || out_ready);
  assign advance  = in_ready;

  // Subtraction is a + ~b + 1, so sub never needs to travel down the pipe.
  assign v_st[0] = in_valid;
  assign a_st[0] = a;
  assign b_st[0] = sub ? ~b : b;
  assign c_st[0] = sub ? 1'b1 : cin;
  assign s_st[0] = '0;

  for (genvar k = 1; k < STAGES; k++) begin : g_link
    assign v_st[k] = vld_q[k-1];
    assign a_st[k] = a_q[k-1];
    assign b_st[k] = b_q[k-1];
    assign c_st[k] = c_q[k-1];
    assign s_st[k] = s_q[k-1];
  end

  always_comb begin
    logic             carry;
    logic             c_msb;
    logic [WIDTH-1:0] s_tmp;
    carry = 1'b0;
    c_msb = 1'b0;
    s_tmp = '0;
    ovf_d = 1'b0;
    vld_d = '0;
    c_d   = '0;
    for (int k = 0; k < STAGES; k++) begin
      a_d[k] = '0;
      b_d[k] = '0;
      s_d[k] = '0;
    end

    for (int k = 0; k < STAGES; k++) begin
      carry = c_st[k];
      c_msb = 1'b0;
      s_tmp = s_st[k];
      for (int j = 0; j < CHUNK; j++) begin
        s_tmp[k*CHUNK+j] = a_st[k][k*CHUNK+j] ^ b_st[k][k*CHUNK+j] ^ carry;
        // After the loop this holds the carry into the slice's top bit. That
        // bit is the word MSB only in the last stage.
        c_msb = carry;
        carry = (a_st[k][k*CHUNK+j] & b_st[k][k*CHUNK+j]) |
                (carry & (a_st[k][k*CHUNK+j] ^ b_st[k][k*CHUNK+j]));
      end
      vld_d[k] = v_st[k];
      a_d[k]   = a_st[k];
      b_d[k]   = b_st[k];
      c_d[k]   = carry;
      if (k == LAST) begin
        ovf_d = c_msb ^ carry;
`ifdef SATURATE_EN
        // On overflow both operand MSBs are equal, and they give the sign of
        // the true result.
        if (c_msb ^ carry) begin
          s_tmp = a_st[k][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                   : {1'b0, {(WIDTH-1){1'b1}}};
        end
`endif
      end
      s_d[k] = s_tmp;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q <= '0;
      c_q   <= '0;
      ovf_q <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
      end
    end else if (advance) begin
      vld_q <= vld_d;
      c_q   <= c_d;
      ovf_q <= ovf_d;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= a_d[k];
        b_q[k] <= b_d[k];
        s_q[k] <= s_d[k];
      end
    end
  end

  assign out_valid = vld_q[LAST];
  assign sum       = s_q[LAST];
  assign cout      = c_q[LAST];
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_pipelined_adder.sv
module tb_pipelined_adder;

  localparam int WIDTH  = 16;
  localparam int STAGES = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n;
  logic             in_valid, in_ready;
  logic [WIDTH-1:0] a, b;
  logic             cin, sub;
  logic             out_valid, out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout, overflow;

  pipelined_adder #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .overflow(overflow)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Result packed as {overflow, cout, sum}, computed with WIDTH+1-bit arithmetic.
  function automatic logic [WIDTH+1:0] model(input logic [WIDTH-1:0] ma,
                                             input logic [WIDTH-1:0] mb,
                                             input logic mcin, input logic msub);
    logic [WIDTH-1:0] bb;
    logic [WIDTH:0]   full;
    logic [WIDTH-1:0] s;
    logic             ov;
    bb   = msub ? ~mb : mb;
    full = {1'b0, ma} + {1'b0, bb} + (WIDTH+1)'(msub ? 1'b1 : mcin);
    s    = full[WIDTH-1:0];
    ov   = (ma[WIDTH-1] == bb[WIDTH-1]) && (s[WIDTH-1] != ma[WIDTH-1]);
`ifdef SATURATE_EN
    if (ov) s = ma[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`endif
    return {ov, full[WIDTH], s};
  endfunction

  // ---------------- scoreboard ----------------
  logic [WIDTH+1:0] exp_q[$];
  int               results = 0;

  always @(negedge clk) begin
    logic [WIDTH+1:0] e;
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_result", 32'(sum), 32'hDEAD);
        end else begin
          e = exp_q.pop_front();
          chk("sum", 32'(sum), 32'(e[WIDTH-1:0]));
          chk("cout", 32'(cout), 32'(e[WIDTH]));
          chk("overflow", 32'(overflow), 32'(e[WIDTH+1]));
          results++;
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model(a, b, cin, sub));
    end
  end

  // ---------------- driver tasks ----------------
  // Present operands and return at posedge+1 after they are accepted.
  task automatic send(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                      input logic tcin, input logic tsub);
    int n;
    a = ta; b = tb; cin = tcin; sub = tsub; in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("send_timeout", 32'(n), 32'(0));
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int n;
    in_valid = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_empty", 32'(exp_q.size()), 32'(0));
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [WIDTH-1:0] held_sum;
    logic             held_cout, held_ovf;
    int               acc, cyc;
    logic             took;

    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'(0));
    chk("rst_sum", 32'(sum), 32'(0));
    chk("rst_cout", 32'(cout), 32'(0));
    chk("rst_overflow", 32'(overflow), 32'(0));
    chk("rst_in_ready", 32'(in_ready), 32'(0));
    rst_n = 1'b1;
    #1;
    chk("in_ready_after_rst", 32'(in_ready), 32'(1));
    @(posedge clk); #1;

    // Wrap-around add and exact latency
    send(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    in_valid = 1'b0;
    for (int i = 0; i < STAGES - 1; i++) begin
      chk("latency_early", 32'(out_valid), 32'(0));
      @(posedge clk); #1;
    end
    chk("latency_valid", 32'(out_valid), 32'(1));
    chk("wrap_sum", 32'(sum), 32'h0000);
    chk("wrap_cout", 32'(cout), 32'(1));
    chk("wrap_ovf", 32'(overflow), 32'(0));
    drain();

    // Signed overflow and subtraction
    send(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    send(16'h0005, 16'h0007, 1'b1, 1'b1);
    send(16'h8000, 16'h0001, 1'b0, 1'b1);
    drain();

    // Back-to-back stream with a 3-cycle output stall
    for (int i = 0; i < 8; i++) begin
      if (i == 4) begin
        out_ready = 1'b0;
        a = WIDTH'(i); b = WIDTH'(16'h1000 * i); cin = 1'(i); sub = 1'b0;
        #1;
        chk("stall_in_ready", 32'(in_ready), 32'(0));
        chk("stall_out_valid", 32'(out_valid), 32'(1));
        held_sum = sum; held_cout = cout; held_ovf = overflow;
        repeat (2) begin
          @(posedge clk); #1;
          chk("stall_in_ready", 32'(in_ready), 32'(0));
          chk("stall_out_valid", 32'(out_valid), 32'(1));
          chk("stall_sum_hold", 32'(sum), 32'(held_sum));
          chk("stall_cout_hold", 32'(cout), 32'(held_cout));
          chk("stall_ovf_hold", 32'(overflow), 32'(held_ovf));
        end
        @(posedge clk); #1;
        chk("stall_sum_hold", 32'(sum), 32'(held_sum));
        out_ready = 1'b1;
      end
      send(WIDTH'(i), WIDTH'(16'h1000 * i), 1'(i), 1'b0);
    end
    drain();

    // Random bubbles on both sides
    acc = 0; cyc = 0; in_valid = 1'b0;
    while (acc < 1000 && cyc < 20000) begin
      if (!in_valid && $urandom_range(0, 1) == 1) begin
        a = WIDTH'($urandom); b = WIDTH'($urandom);
        cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
        in_valid = 1'b1;
      end
      out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      took = in_valid && in_ready;
      @(posedge clk); #1;
      if (took) begin
        acc++;
        in_valid = 1'b0;
      end
      cyc++;
    end
    chk("random_accepted", 32'(acc), 32'(1000));
    drain();

    // Reset with 3 results in flight
    send(16'h1111, 16'h2222, 1'b0, 1'b0);
    send(16'h3333, 16'h4444, 1'b1, 1'b0);
    send(16'h5555, 16'h0005, 1'b0, 1'b1);
    in_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("midrst_out_valid", 32'(out_valid), 32'(0));
    chk("midrst_sum", 32'(sum), 32'(0));
    repeat (STAGES + 2) begin
      @(posedge clk); #1;
      chk("no_stale_result", 32'(out_valid), 32'(0));
    end
    send(16'h0102, 16'h0304, 1'b1, 1'b0);
    in_valid = 1'b0;
    for (int i = 0; i < STAGES - 1; i++) begin
      chk("post_rst_latency_early", 32'(out_valid), 32'(0));
      @(posedge clk); #1;
    end
    chk("post_rst_latency_valid", 32'(out_valid), 32'(1));
    chk("post_rst_sum", 32'(sum), 32'h0407);
    drain();
    chk("result_count", 32'(results), 32'(1 + 3 + 8 + 1000 + 1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
